// File: rtl/capture_pkg.sv
// Shared definitions for the capture path: frame-gate state encoding and
// the default pixel width.
package capture_pkg;

    localparam int PIX_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } gate_state_t;

endpackage

// File: rtl/stat_counter.sv
// Free-running statistics counter; wraps modulo 2^CNT_W.
module stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/frame_gate_ctrl.sv
// Frame scheduler: decides at each vsync rise whether the whole next frame
// reaches the encoder, applying the rate divider and encoder back-pressure.
module frame_gate_ctrl
    import capture_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] frame_div,
    input  logic             enc_busy,
    input  logic             in_pvalid,
    input  logic             in_vsync,
    input  logic [PIX_W-1:0] in_ycbcr,
    output logic             out_pvalid,
    output logic             out_vsync,
    output logic [PIX_W-1:0] out_ycbcr,
    output logic             frame_start,
    output logic             frame_pass,
    output logic [CNT_W-1:0] cnt_seen,
    output logic [CNT_W-1:0] cnt_passed,
    output logic [CNT_W-1:0] cnt_drop_busy
);

    gate_state_t      r_state;
    gate_state_t      w_state_nxt;
    logic             r_vsync_d;
    logic [DIV_W-1:0] r_sc;
    logic             r_out_pvalid;
    logic             r_out_vsync;
    logic [PIX_W-1:0] r_out_ycbcr;
    logic             r_frame_start;

    logic             w_bnd;
    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W:0]   w_sc_inc;
    logic             w_slot;
    logic             w_pass_now;
    logic             w_busy_drop;
    logic             w_gate;

    assign w_bnd       = in_vsync & ~r_vsync_d;
    assign w_div_eff   = (frame_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : frame_div;
    assign w_sc_inc    = {1'b0, r_sc} + 1'b1;
    assign w_slot      = enable & (r_sc == '0);
    assign w_pass_now  = w_slot & ~enc_busy;
    assign w_busy_drop = w_slot & enc_busy;
    // On the boundary cycle the new decision already applies to the vsync itself.
    assign w_gate      = w_bnd ? w_pass_now : (r_state == PASS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vsync_d <= 1'b0;
            r_sc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= in_vsync;
            if (w_bnd) begin
                // A divider shrunk below the current count wraps to 0 here.
                r_sc <= (w_sc_inc >= {1'b0, w_div_eff}) ? '0 : w_sc_inc[DIV_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_bnd) begin
            w_state_nxt = w_pass_now ? PASS : DROP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_pvalid  <= 1'b0;
            r_out_vsync   <= 1'b0;
            r_out_ycbcr   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_out_pvalid  <= in_pvalid & w_gate;
            r_out_vsync   <= in_vsync & w_gate;
            r_out_ycbcr   <= in_ycbcr;
            r_frame_start <= w_bnd;
        end
    end

    stat_counter #(.CNT_W(CNT_W)) u_cnt_seen (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bnd),
        .cnt   (cnt_seen)
    );

    stat_counter #(.CNT_W(CNT_W)) u_cnt_passed (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bnd & w_pass_now),
        .cnt   (cnt_passed)
    );

    stat_counter #(.CNT_W(CNT_W)) u_cnt_drop_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bnd & w_busy_drop),
        .cnt   (cnt_drop_busy)
    );

    assign out_pvalid  = r_out_pvalid;
    assign out_vsync   = r_out_vsync;
    assign out_ycbcr   = r_out_ycbcr;
    assign frame_start = r_frame_start;
    assign frame_pass  = (r_state == PASS);

endmodule

// File: tb/tb_frame_gate_ctrl.sv
// Self-checking bench for frame_gate_ctrl: per-cycle scoreboard against a
// frame-level reference plus table-driven frame statistics checks.
module tb_frame_gate_ctrl;

    localparam int PIX_W   = 24;
    localparam int DIV_W   = 4;
    localparam int CNT_W   = 16;
    localparam int FR_LEN  = 100;
    localparam int PV_LEN  = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] frame_div = '0;
    logic             enc_busy = 1'b0;
    logic             in_pvalid = 1'b0;
    logic             in_vsync = 1'b0;
    logic [PIX_W-1:0] in_ycbcr = '0;
    logic             out_pvalid, out_vsync, frame_start, frame_pass;
    logic [PIX_W-1:0] out_ycbcr;
    logic [CNT_W-1:0] cnt_seen, cnt_passed, cnt_drop_busy;

    frame_gate_ctrl #(.PIX_W(PIX_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_div     (frame_div),
        .enc_busy      (enc_busy),
        .in_pvalid     (in_pvalid),
        .in_vsync      (in_vsync),
        .in_ycbcr      (in_ycbcr),
        .out_pvalid    (out_pvalid),
        .out_vsync     (out_vsync),
        .out_ycbcr     (out_ycbcr),
        .frame_start   (frame_start),
        .frame_pass    (frame_pass),
        .cnt_seen      (cnt_seen),
        .cnt_passed    (cnt_passed),
        .cnt_drop_busy (cnt_drop_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pv;
        logic             vs;
        logic             fs;
        logic             fp;
        logic [PIX_W-1:0] pix;
        logic [CNT_W-1:0] seen;
        logic [CNT_W-1:0] passed;
        logic [CNT_W-1:0] drop;
    } obs_t;

    typedef struct {
        logic [DIV_W-1:0] div;
        logic             en;
        logic [7:0]       busy_mask;
        int               nfr;
        int               exp_seen;
        int               exp_passed;
        int               exp_drop;
        int               exp_pv;
    } vec_t;

    obs_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pv_cnt = 0;

    // Reference state, kept at frame granularity.
    logic             m_vd;
    int               m_sc;
    logic             m_pass;
    logic [CNT_W-1:0] m_seen, m_passed, m_drop;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_vd = 1'b0; m_sc = 0; m_pass = 1'b0;
        m_seen = '0; m_passed = '0; m_drop = '0;
        q.delete();
        pv_cnt = 0;
    endtask

    function automatic obs_t sample();
        obs_t a;
        a.pv = out_pvalid; a.vs = out_vsync; a.fs = frame_start; a.fp = frame_pass;
        a.pix = out_ycbcr; a.seen = cnt_seen; a.passed = cnt_passed; a.drop = cnt_drop_busy;
        return a;
    endfunction

    task automatic cyc(input logic pv, input logic vs);
        obs_t e;
        obs_t a;
        logic [PIX_W-1:0] pix;
        logic bnd, pn, g;
        int div;
        pix = PIX_W'($urandom);
        in_pvalid = pv; in_vsync = vs; in_ycbcr = pix;
        bnd = vs && !m_vd;
        div = (frame_div == 0) ? 1 : int'(frame_div);
        pn  = enable && (m_sc == 0) && !enc_busy;
        g   = bnd ? pn : m_pass;
        if (bnd) begin
            m_seen++;
            if (pn) m_passed++;
            if (enable && (m_sc == 0) && enc_busy) m_drop++;
            m_pass = pn;
            m_sc = (m_sc + 1 >= div) ? 0 : m_sc + 1;
        end
        m_vd = vs;
        e.pv = pv & g; e.vs = vs & g; e.fs = bnd; e.fp = m_pass; e.pix = pix;
        e.seen = m_seen; e.passed = m_passed; e.drop = m_drop;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        a = sample();
        if (out_pvalid) pv_cnt++;
        check("cycle", 128'(a), 128'(e));
    endtask

    task automatic frame(input int upto);
        for (int c = 0; c < upto; c++) begin
            cyc((c >= 10) && (c < 10 + PV_LEN), c < 3);
        end
    endtask

    task automatic do_reset();
        obs_t a;
        rst_n = 1'b0;
        in_pvalid = 1'b0; in_vsync = 1'b0;
        #1;
        a = sample();
        check("reset_outputs", 128'(a), 128'(0));
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_counts(input string name, input int s, input int p, input int d);
        check({name, "_seen"},   128'(cnt_seen),      128'(s));
        check({name, "_passed"}, 128'(cnt_passed),    128'(p));
        check({name, "_drop"},   128'(cnt_drop_busy), 128'(d));
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{div: 4'd0, en: 1'b1, busy_mask: 8'b0000_0000, nfr: 4, exp_seen: 4, exp_passed: 4, exp_drop: 0, exp_pv: 4*PV_LEN};
        vecs[1] = '{div: 4'd3, en: 1'b1, busy_mask: 8'b0000_0000, nfr: 7, exp_seen: 7, exp_passed: 3, exp_drop: 0, exp_pv: 3*PV_LEN};
        vecs[2] = '{div: 4'd1, en: 1'b1, busy_mask: 8'b0000_0110, nfr: 5, exp_seen: 5, exp_passed: 3, exp_drop: 2, exp_pv: 3*PV_LEN};

        #2;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            frame_div = vecs[v].div;
            enable    = vecs[v].en;
            for (int f = 0; f < vecs[v].nfr; f++) begin
                enc_busy = vecs[v].busy_mask[f];
                frame(FR_LEN);
            end
            check_counts($sformatf("vec%0d", v), vecs[v].exp_seen, vecs[v].exp_passed, vecs[v].exp_drop);
            check($sformatf("vec%0d_pv_total", v), 128'(pv_cnt), 128'(vecs[v].exp_pv));
        end

        // enable/enc_busy changed in the middle of a forwarded frame
        do_reset();
        frame_div = 4'd1; enable = 1'b1; enc_busy = 1'b0;
        for (int c = 0; c < FR_LEN; c++) begin
            if (c == 15) begin enc_busy = 1'b1; enable = 1'b0; end
            cyc((c >= 10) && (c < 10 + PV_LEN), c < 3);
        end
        check("midframe_pv_kept", 128'(pv_cnt), 128'(PV_LEN));
        frame(FR_LEN);
        check("next_frame_dropped", 128'(pv_cnt), 128'(PV_LEN));
        check_counts("midframe", 2, 1, 0);
        enable = 1'b1;
        frame(FR_LEN);
        check_counts("busy_enabled", 3, 1, 1);

        // pixels before the first vsync rise are never forwarded
        do_reset();
        frame_div = 4'd0; enable = 1'b1; enc_busy = 1'b0;
        for (int c = 0; c < 30; c++) cyc(1'b1, 1'b0);
        check("pre_vsync_seen", 128'(cnt_seen), 128'(0));
        check("pre_vsync_pv", 128'(pv_cnt), 128'(0));
        frame(FR_LEN);
        check("first_frame_seen", 128'(cnt_seen), 128'(1));
        check("first_frame_pv", 128'(pv_cnt), 128'(PV_LEN));

        // asynchronous reset in the middle of a forwarded frame
        frame(15);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 128'(sample()), 128'(0));
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0);
        check("post_reset_seen", 128'(cnt_seen), 128'(0));
        check("post_reset_pv", 128'(pv_cnt), 128'(0));
        frame(FR_LEN);
        check("post_reset_frame_seen", 128'(cnt_seen), 128'(1));
        check("post_reset_frame_pv", 128'(pv_cnt), 128'(PV_LEN));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_gate_ctrl.md
Name: frame_gate_ctrl

Overview:
- Frame scheduler between the TMDS token decoder and the MJPG encoder.
- Detects frame boundaries on the decoded vsync. Decides per frame whether the whole frame goes to the encoder or is dropped.
- Supports a programmable frame-rate divider and drops frames while the encoder is still busy, so a partial frame never reaches the encoder.
- Exposes frame statistics counters for debug and LED readout.

Parameters:
- PIX_W, 24, pixel word width (YCbCr 8:8:8).
- DIV_W, 4, width of the frame-divider input.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pixel-data clock (TMDS recovered pixel clock).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = forwarding allowed; sampled only at frame boundaries.
- frame_div  in  DIV_W  forward 1 of every N frames; 0 is treated as 1.
- enc_busy  in  1  encoder still emitting the previous frame; sampled at frame boundary.
- in_pvalid  in  1  active-pixel qualifier from the token decoder.
- in_vsync  in  1  vsync level from the token decoder.
- in_ycbcr  in  PIX_W  pixel data.
- out_pvalid  out  1  gated pixel valid to the encoder.
- out_vsync  out  1  gated vsync to the encoder.
- out_ycbcr  out  PIX_W  registered pixel data.
- frame_start  out  1  one-cycle pulse on every detected frame boundary.
- frame_pass  out  1  level; 1 while the current frame is forwarded.
- cnt_seen  out  CNT_W  frame boundaries detected.
- cnt_passed  out  CNT_W  frames forwarded.
- cnt_drop_busy  out  CNT_W  frames dropped because enc_busy was 1.

Behaviour:
- Reset values: all outputs 0, state IDLE, skip counter 0, vsync_d 0. Reset is asynchronous and active-low; all flops clear immediately when rst_n is low.
- Frame boundary: bnd = in_vsync & ~vsync_d, where vsync_d is in_vsync registered one cycle.
- frame_start = registered bnd, so it pulses 1 cycle after the rising vsync cycle.
- Effective divider: div_eff = (frame_div==0) ? 1 : frame_div.
- Skip counter sc, range 0..div_eff-1:
  - On each bnd: sc <= (sc+1 >= div_eff) ? 0 : sc+1.
  - frame_div is sampled only at bnd.
  - If frame_div changes so that sc >= div_eff, the next bnd wraps sc to 0.
- Pass decision, combinational, evaluated at bnd: pass_now = enable & (sc==0) & ~enc_busy.
- States:
  - IDLE: after reset; nothing forwarded. On bnd go to PASS if pass_now, else DROP.
  - PASS: forwarding. On bnd re-evaluate pass_now: go to PASS or DROP.
  - DROP: blocking. On bnd re-evaluate the same way.
- Mid-frame changes: enable or enc_busy changing mid-frame have no effect until the next bnd. The current frame always completes or stays dropped.
- Outputs, 1-cycle latency from inputs:
  - out_ycbcr <= in_ycbcr (always, ungated).
  - out_pvalid <= in_pvalid & gate.
  - out_vsync <= in_vsync & gate.
  - gate = bnd ? pass_now : (state==PASS).
  - frame_pass mirrors (state==PASS).
- Counters, updated on the cycle after bnd:
  - cnt_seen increments on every bnd.
  - cnt_passed increments when pass_now.
  - cnt_drop_busy increments when enable & (sc==0) & enc_busy.
  - All counters wrap modulo 2^CNT_W.
- Invariant: cnt_passed + cnt_drop_busy <= cnt_seen (mod wrap).
- in_pvalid high while in IDLE is never forwarded, which prevents a partial first frame after reset.
- A bnd on the very first cycle after reset release is valid, because vsync_d resets to 0.

Decomposition:
- Shared package capture_pkg:
  - state encoding typedef: IDLE=2'd0, PASS=2'd1, DROP=2'd2.
  - PIX_W default constant.
- No sub-module. Optionally one generic counter sub-module, stat_counter (CNT_W, inc, wrap), instantiated three times.

Test Plan:
- frame_div=0, enable=1, enc_busy=0, 4 frames (vsync rise every 1000 cycles, 200 pvalid cycles each) -> first frame after reset forwarded; out_pvalid 800 cycles total, 1 cycle late; cnt_seen=4, cnt_passed=4.
- frame_div=3, 7 frames -> frames 1,4,7 forwarded; cnt_passed=3, cnt_drop_busy=0, cnt_seen=7.
- frame_div=1, enc_busy=1 at boundaries 2 and 3 only, 5 frames -> frames 2,3 dropped; cnt_drop_busy=2, cnt_passed=3.
- enc_busy or enable toggled mid-frame in a PASS frame -> out_pvalid unaffected for the rest of that frame; change takes effect at the next boundary.
- in_pvalid active before the first vsync rise after reset -> out_pvalid stays 0 until the first boundary; cnt_seen=0 until then.
- rst_n asserted mid-frame (async, not clock-aligned) -> all outputs 0 immediately. After release, nothing forwarded until the next vsync rise, which increments cnt_seen to 1.
